// File: rtl/alexnet_pkg.sv
// Shared AlexNet types and constants for the argmax classifier stage.
// The optional runner-up tracking is enabled with the ARGMAX_TOP2_EN macro.
package alexnet_pkg;

    localparam int DW          = 16;
    localparam int NUM_CLASSES = 10;
    localparam int IW          = 4;

    typedef logic signed [DW-1:0] score_t;
    typedef logic [IW-1:0]        class_idx_t;

    localparam score_t SCORE_MIN = {1'b1, {(DW-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        FINISH
    } argmax_state_t;

endpackage

// File: rtl/argmax_cmp.sv
// Combinational update of the running (best, second) pair for one accepted score.
// Runner-up ports exist only when ARGMAX_TOP2_EN is defined.
module argmax_cmp
    import alexnet_pkg::*;
(
    input  score_t     score_i,
    input  class_idx_t cnt_i,
    input  class_idx_t best_idx_i,
    input  score_t     best_score_i,
`ifdef ARGMAX_TOP2_EN
    input  class_idx_t second_idx_i,
    input  score_t     second_score_i,
    output class_idx_t second_idx_o,
    output score_t     second_score_o,
`endif
    output class_idx_t best_idx_o,
    output score_t     best_score_o
);

    logic first;
    logic new_max;

    assign first   = (cnt_i == '0);
    // Strict compare: an equal score never displaces an earlier index.
    assign new_max = first || (score_i > best_score_i);

    always_comb begin
        best_idx_o   = best_idx_i;
        best_score_o = best_score_i;
`ifdef ARGMAX_TOP2_EN
        second_idx_o   = second_idx_i;
        second_score_o = second_score_i;
`endif
        if (new_max) begin
            best_idx_o   = cnt_i;
            best_score_o = score_i;
`ifdef ARGMAX_TOP2_EN
            if (!first) begin
                second_idx_o   = best_idx_i;
                second_score_o = best_score_i;
            end
`endif
        end
`ifdef ARGMAX_TOP2_EN
        else if ((cnt_i == class_idx_t'(1)) || (score_i > second_score_i)) begin
            second_idx_o   = cnt_i;
            second_score_o = score_i;
        end
`endif
    end

endmodule

// File: rtl/fc_argmax_classifier.sv
// Argmax over the serial fc3/ReLU class-score stream; pulses done with the winner.
// Define ARGMAX_TOP2_EN to also report the runner-up class and score.
module fc_argmax_classifier
    import alexnet_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          score_valid,
    input  logic [DW-1:0] score_in,
    output logic          busy,
    output logic          done,
`ifdef ARGMAX_TOP2_EN
    output logic [IW-1:0] second_idx,
    output logic [DW-1:0] second_score,
`endif
    output logic [IW-1:0] class_idx,
    output logic [DW-1:0] class_score
);

    argmax_state_t state_q, state_d;
    class_idx_t    cnt_q, cnt_d;
    class_idx_t    best_idx_q, best_idx_d;
    score_t        best_score_q, best_score_d;
    class_idx_t    class_idx_q, class_idx_d;
    score_t        class_score_q, class_score_d;
    class_idx_t    nb_idx;
    score_t        nb_score;

`ifdef ARGMAX_TOP2_EN
    class_idx_t run_sidx_q, run_sidx_d;
    score_t     run_sscore_q, run_sscore_d;
    class_idx_t sec_idx_q, sec_idx_d;
    score_t     sec_score_q, sec_score_d;
    class_idx_t ns_idx;
    score_t     ns_score;
`endif

    argmax_cmp u_cmp (
        .score_i        (score_t'(score_in)),
        .cnt_i          (cnt_q),
        .best_idx_i     (best_idx_q),
        .best_score_i   (best_score_q),
`ifdef ARGMAX_TOP2_EN
        .second_idx_i   (run_sidx_q),
        .second_score_i (run_sscore_q),
        .second_idx_o   (ns_idx),
        .second_score_o (ns_score),
`endif
        .best_idx_o     (nb_idx),
        .best_score_o   (nb_score)
    );

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        best_idx_d    = best_idx_q;
        best_score_d  = best_score_q;
        class_idx_d   = class_idx_q;
        class_score_d = class_score_q;
`ifdef ARGMAX_TOP2_EN
        run_sidx_d   = run_sidx_q;
        run_sscore_d = run_sscore_q;
        sec_idx_d    = sec_idx_q;
        sec_score_d  = sec_score_q;
`endif
        // start in IDLE and in SCAN share the same clear; it is ignored in FINISH.
        if (start && (state_q != FINISH)) begin
            state_d      = SCAN;
            cnt_d        = '0;
            best_idx_d   = '0;
            best_score_d = SCORE_MIN;
`ifdef ARGMAX_TOP2_EN
            run_sidx_d   = '0;
            run_sscore_d = SCORE_MIN;
`endif
        end else begin
            case (state_q)
                SCAN: begin
                    if (score_valid) begin
                        cnt_d        = cnt_q + 1'b1;
                        best_idx_d   = nb_idx;
                        best_score_d = nb_score;
`ifdef ARGMAX_TOP2_EN
                        run_sidx_d   = ns_idx;
                        run_sscore_d = ns_score;
`endif
                        if (cnt_q == class_idx_t'(NUM_CLASSES - 1)) begin
                            state_d       = FINISH;
                            class_idx_d   = nb_idx;
                            class_score_d = nb_score;
`ifdef ARGMAX_TOP2_EN
                            sec_idx_d     = ns_idx;
                            sec_score_d   = ns_score;
`endif
                        end
                    end
                end
                FINISH:  state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            best_idx_q    <= '0;
            best_score_q  <= SCORE_MIN;
            class_idx_q   <= '0;
            class_score_q <= '0;
`ifdef ARGMAX_TOP2_EN
            run_sidx_q    <= '0;
            run_sscore_q  <= SCORE_MIN;
            sec_idx_q     <= '0;
            sec_score_q   <= '0;
`endif
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            best_idx_q    <= best_idx_d;
            best_score_q  <= best_score_d;
            class_idx_q   <= class_idx_d;
            class_score_q <= class_score_d;
`ifdef ARGMAX_TOP2_EN
            run_sidx_q    <= run_sidx_d;
            run_sscore_q  <= run_sscore_d;
            sec_idx_q     <= sec_idx_d;
            sec_score_q   <= sec_score_d;
`endif
        end
    end

    assign busy        = (state_q == SCAN);
    assign done        = (state_q == FINISH);
    assign class_idx   = class_idx_q;
    assign class_score = class_score_q;
`ifdef ARGMAX_TOP2_EN
    assign second_idx   = sec_idx_q;
    assign second_score = sec_score_q;
`endif

endmodule

// File: tb/tb_fc_argmax_classifier.sv
// Scoreboard bench for fc_argmax_classifier; runner-up outputs are checked under ARGMAX_TOP2_EN.
module tb_fc_argmax_classifier;
    import alexnet_pkg::*;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          score_valid;
    logic [DW-1:0] score_in;
    logic          busy;
    logic          done;
    logic [IW-1:0] class_idx;
    logic [DW-1:0] class_score;
`ifdef ARGMAX_TOP2_EN
    logic [IW-1:0] second_idx;
    logic [DW-1:0] second_score;
`endif

    fc_argmax_classifier dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .score_valid  (score_valid),
        .score_in     (score_in),
        .busy         (busy),
        .done         (done),
`ifdef ARGMAX_TOP2_EN
        .second_idx   (second_idx),
        .second_score (second_score),
`endif
        .class_idx    (class_idx),
        .class_score  (class_score)
    );

    always #5 clk = ~clk;

    typedef struct {
        int     idx;
        int     score;
        int     sidx;
        int     sscore;
        longint cyc;
    } exp_t;

    exp_t   q[$];
    int     checks = 0;
    int     errors = 0;
    longint cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: first index holding the maximum; runner-up is the best of the rest.
    function automatic exp_t model(input score_t s[NUM_CLASSES]);
        exp_t e;
        int bi = 0;
        int si = -1;
        for (int i = 1; i < NUM_CLASSES; i++)
            if (s[i] > s[bi]) bi = i;
        for (int i = 0; i < NUM_CLASSES; i++)
            if (i != bi && (si < 0 || s[i] > s[si])) si = i;
        e.idx    = bi;
        e.score  = int'(s[bi]);
        e.sidx   = (si < 0) ? 0 : si;
        e.sscore = (si < 0) ? int'(SCORE_MIN) : int'(s[si]);
        e.cyc    = 0;
        return e;
    endfunction

    always @(negedge clk) begin
        if (!rst && done) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no done (t=%0t)", $time);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("done_cycle", cyc, e.cyc);
                chk("class_idx", longint'(class_idx), e.idx);
                chk("class_score", longint'($signed(class_score)), e.score);
                chk("busy_with_done", longint'(busy), 0);
`ifdef ARGMAX_TOP2_EN
                chk("second_idx", longint'(second_idx), e.sidx);
                chk("second_score", longint'($signed(second_score)), e.sscore);
`endif
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input bit early);
        start       = 1'b1;
        score_valid = early;
        score_in    = 16'h7FFF;
        tick();
        start       = 1'b0;
        score_valid = 1'b0;
    endtask

    task automatic send(input score_t v, input int gap);
        repeat (gap) tick();
        score_valid = 1'b1;
        score_in    = v;
        tick();
        score_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (q.size() != 0 && n < 20) begin
            tick();
            n++;
        end
        chk("drain_timeout", q.size(), 0);
        q.delete();
        tick();
    endtask

    task automatic run(input score_t s[NUM_CLASSES], input int maxgap, input bit early);
        exp_t e;
        e = model(s);
        pulse_start(early);
        chk("busy_scan", longint'(busy), 1);
        for (int i = 0; i < NUM_CLASSES; i++) begin
            int gap = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
            repeat (gap) tick();
            score_valid = 1'b1;
            score_in    = s[i];
            if (i == NUM_CLASSES - 1) begin
                e.cyc = cyc + 1;
                q.push_back(e);
            end
            tick();
            score_valid = 1'b0;
        end
        wait_drain();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"}, longint'(busy), 0);
        chk({tag, "_done"}, longint'(done), 0);
        chk({tag, "_class_idx"}, longint'(class_idx), 0);
        chk({tag, "_class_score"}, longint'(class_score), 0);
`ifdef ARGMAX_TOP2_EN
        chk({tag, "_second_idx"}, longint'(second_idx), 0);
        chk({tag, "_second_score"}, longint'(second_score), 0);
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        score_t s[NUM_CLASSES];
        score_t basic[NUM_CLASSES] = '{5, -3, 12, 7, 0, 1, 2, 3, 4, -8};

        rst = 1'b1; start = 1'b0; score_valid = 1'b0; score_in = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rst = 1'b0;
        tick();

        run(basic, 0, 1'b0);

        for (int i = 0; i < NUM_CLASSES; i++) s[i] = -100;
        s[4] = -7; s[7] = -7;
        run(s, 0, 1'b0);

        for (int i = 0; i < NUM_CLASSES; i++) s[i] = SCORE_MIN;
        run(s, 0, 1'b0);

        for (int i = 0; i < NUM_CLASSES; i++) s[i] = score_t'(int'($urandom_range(0, 299)) - 150);
        s[9] = 300;
        run(s, 4, 1'b1);

        // Abort: partial run with a larger max is discarded by a second start.
        pulse_start(1'b0);
        send(10, 0); send(50, 0); send(3, 0); send(-4, 0);
        for (int i = 0; i < NUM_CLASSES; i++) s[i] = score_t'(i);
        s[6] = 20;
        run(s, 0, 1'b0);

        pulse_start(1'b0);
        for (int i = 0; i < 5; i++) send(score_t'(i * 7 - 3), 0);
        #2;
        rst = 1'b1;
        #1;
        chk_reset_outputs("midscan_reset");
        tick();
        tick();
        rst = 1'b0;
        tick();
        run(basic, 1, 1'b0);

`ifdef ARGMAX_TOP2_EN
        s = '{9, 3, 15, 15, 2, 1, 0, -5, 8, 4};
        run(s, 0, 1'b0);
`endif

        for (int r = 0; r < 20; r++) begin
            for (int i = 0; i < NUM_CLASSES; i++) begin
                if (r % 2 == 0) s[i] = score_t'(int'($urandom_range(0, 6)) - 3);
                else            s[i] = score_t'($urandom);
            end
            run(s, 3, r[0]);
        end

        chk("queue_empty", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fc_argmax_classifier.md
Name: fc_argmax_classifier

Overview:
- Terminal stage of the AlexNet pipeline, sitting directly downstream of the final fully-connected layer and its output activation (fc3 → ReLU_out).
- Consumes the serial stream of NUM_CLASSES signed class scores and tracks the running maximum.
- Emits the winning class index and its score with a one-cycle done pulse, so the top level can drive result LEDs and the overall Done flag.

Parameters:
- NUM_CLASSES, 10, number of scores per classification (≥1).
- DW, 16, score width (signed two's complement, matches ReLU_o width).
- IW, 4, class-index width; must satisfy 2**IW ≥ NUM_CLASSES.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- start  in  1  one-cycle pulse that begins a new classification.
- score_valid  in  1  score_in carries a valid class score this cycle.
- score_in  in  DW  signed class score, class order 0..NUM_CLASSES-1.
- busy  out  1  high while scanning.
- done  out  1  single-cycle pulse when the result is valid.
- class_idx  out  IW  index of the maximum score; held until the next done.
- class_score  out  DW  maximum score; held until the next done.

Behaviour:
- Reset (async, rst=1): state=IDLE; busy=0, done=0, class_idx=0, class_score=0; cnt=0, best_idx=0, best_score=SCORE_MIN.
- FSM states: IDLE, SCAN, FINISH.
- IDLE:
  - start=1 → SCAN next cycle, with cnt=0, best_score=SCORE_MIN, best_idx=0, busy=1.
  - score_valid in IDLE is ignored.
  - A score presented in the same cycle as start is NOT accepted; the first score is accepted the cycle after start.
- SCAN, on each score_valid=1:
  - Compare: if cnt==0 OR score_in > best_score (signed, strict), then best_score←score_in and best_idx←cnt.
  - cnt←cnt+1.
  - score_valid=0 cycles stall without state change; there is no timeout.
- SCAN exit: when a score is accepted with cnt==NUM_CLASSES-1 → FINISH.
- FINISH (one cycle):
  - done=1, busy=0.
  - class_idx and class_score are loaded with the final best (the last score is included in the compare).
  - Next cycle → IDLE.
- Latency: done is asserted exactly 1 cycle after the last score is accepted.
- Ties: the lowest index wins, because the compare is strict.
- start while in SCAN: aborts and restarts — counters and best are cleared, no done, outputs keep their old result.
- start while in FINISH: ignored.
- score_valid while in FINISH: ignored.
- NUM_CLASSES==1: the single accepted score goes straight to FINISH.
- Arithmetic: pure signed compare; no arithmetic on scores, so no overflow is possible.
- rst mid-SCAN: all outputs go to their reset values immediately and no done is produced.

Optional Feature:
- Macro: ARGMAX_TOP2_EN.
- With the macro defined:
  - Adds output ports second_idx (IW) and second_score (DW), reset to 0.
  - Tracks the runner-up. A new maximum demotes the old best to second. Otherwise, if score_in > second_score (or this is the second accepted score), the score replaces second.
  - Ties keep the lower index.
  - second_idx and second_score update together with class_idx in FINISH.
  - With NUM_CLASSES==1: second_idx=0 and second_score=SCORE_MIN.
- Without the macro: these ports and their registers do not exist.

Decomposition:
- Shared package alexnet_pkg holds:
  - DW, NUM_CLASSES, IW constants;
  - typedef score_t (signed DW) and class_idx_t (IW);
  - SCORE_MIN constant (most-negative score_t);
  - FSM state enum argmax_state_t.
- One natural sub-module, argmax_cmp:
  - combinational compare/update of the (best, second) pair given score_in and cnt;
  - instantiated once;
  - keeps the top level as FSM plus registers.

Test Plan:
- Basic: start, then scores 5,-3,12,7,0,1,2,3,4,-8 → done 1 cycle after the 10th score; class_idx=2, class_score=12; busy low with done.
- Tie and negatives: all scores -100 except idx4=-7 and idx7=-7 → class_idx=4, class_score=-7 (lowest index wins); all ten = -32768 → class_idx=0.
- Stalls and an early score: score_valid driven in the start cycle (ignored), then scores with random gaps, max 300 at idx9 → class_idx=9, done only after the 10th accepted score.
- Abort: start, 4 scores (max 50 at idx1), start again, then 10 scores with max 20 at idx6 → a single done; class_idx=6, class_score=20.
- Reset mid-scan: rst asserted after 5 scores → busy, done, class_idx, class_score = 0 asynchronously; a fresh run afterwards is correct.
- ARGMAX_TOP2_EN: scores 9,3,15,15,2,… (rest <9) → class_idx=2, score 15; second_idx=3, second_score=15.
